// File: rtl/forward_ctrl.sv
// Operand-forwarding and load-use hazard control for a three-stage write-back shadow (EX/MEM/WB).
// Optional stall-cycle counter enabled by defining FWD_STALL_CNT_EN.
module forward_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_rs,
  input  logic        id_uses_rs,
  input  logic        id_use_imm,
  input  logic [3:0]  id_rd,
  input  logic        id_wr,
  input  logic        id_is_load,
  input  logic        flush,
  output logic [2:0]  fwd_sel,
  output logic        stall
`ifdef FWD_STALL_CNT_EN
  ,output logic [15:0] stall_cnt
`endif
);

  typedef struct packed {
    logic       valid;
    logic [3:0] rd;
    logic       is_load;
  } slot_t;

  localparam slot_t EMPTY_SLOT = 6'b000000;

  localparam logic [2:0] SEL_RF  = 3'b000;
  localparam logic [2:0] SEL_EX  = 3'b001;
  localparam logic [2:0] SEL_MEM = 3'b010;
  localparam logic [2:0] SEL_WB  = 3'b011;
  localparam logic [2:0] SEL_IMM = 3'b100;

  function automatic logic slot_hit(input slot_t s, input logic [3:0] rs);
    return s.valid && (s.rd == rs);
  endfunction

  slot_t      ex_r;
  slot_t      mem_r;
  slot_t      wb_r;
  logic       reads_reg_s;
  logic       ex_hit_s;
  logic       mem_hit_s;
  logic       wb_hit_s;
  logic       stall_s;
  logic [2:0] fwd_sel_s;

  // Hazard detection and youngest-first forward selection
  always_comb begin
    reads_reg_s = id_valid && id_uses_rs && !id_use_imm && (id_rs != 4'h0);
    ex_hit_s    = slot_hit(ex_r, id_rs);
    mem_hit_s   = slot_hit(mem_r, id_rs);
    wb_hit_s    = slot_hit(wb_r, id_rs);
    stall_s     = reads_reg_s && ex_hit_s && ex_r.is_load;
    fwd_sel_s   = SEL_RF;
    if (id_use_imm) begin
      fwd_sel_s = SEL_IMM;
    end else if (!reads_reg_s) begin
      fwd_sel_s = SEL_RF;
    end else if (ex_hit_s) begin
      fwd_sel_s = SEL_EX;
    end else if (mem_hit_s) begin
      fwd_sel_s = SEL_MEM;
    end else if (wb_hit_s) begin
      fwd_sel_s = SEL_WB;
    end else begin
      fwd_sel_s = SEL_RF;
    end
  end

  assign fwd_sel = fwd_sel_s;
  assign stall   = stall_s;

  // Write-record pipeline; a stall injects a bubble, flush empties every slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_r  <= EMPTY_SLOT;
      mem_r <= EMPTY_SLOT;
      wb_r  <= EMPTY_SLOT;
    end else if (flush) begin
      ex_r  <= EMPTY_SLOT;
      mem_r <= EMPTY_SLOT;
      wb_r  <= EMPTY_SLOT;
    end else begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      if (stall_s) begin
        ex_r <= EMPTY_SLOT;
      end else begin
        ex_r <= '{valid: id_valid && id_wr, rd: id_rd, is_load: id_is_load};
      end
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of load-use stall cycles that were not flushed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (stall_s && !flush && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
// Self-checking bench for forward_ctrl: directed vector table, hand-written reset
// sequences, and randomized traffic checked against a history-queue model.
module tb_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_rs;
  logic       id_uses_rs;
  logic       id_use_imm;
  logic [3:0] id_rd;
  logic       id_wr;
  logic       id_is_load;
  logic       flush;
  logic [2:0] fwd_sel;
  logic       stall;
`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  forward_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_uses_rs (id_uses_rs),
    .id_use_imm (id_use_imm),
    .id_rd      (id_rd),
    .id_wr      (id_wr),
    .id_is_load (id_is_load),
    .flush      (flush),
    .fwd_sel    (fwd_sel),
    .stall      (stall)
`ifdef FWD_STALL_CNT_EN
    ,.stall_cnt (stall_cnt)
`endif
  );

  // Model: history of the last three issued write records, youngest first.
  typedef struct {
    bit       v;
    bit [3:0] rd;
    bit       ld;
  } rec_t;

  typedef struct {
    bit       v;
    bit [3:0] rs;
    bit       u;
    bit       imm;
    bit [3:0] rd;
    bit       wr;
    bit       ld;
    bit       fl;
    bit [2:0] esel;
    bit       est;
  } vec_t;

  rec_t hist[$];
  vec_t tbl[$];
  int   m_cnt;
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(bit v, bit [3:0] rs, bit u, bit imm, bit [3:0] rd,
                              bit wr, bit ld, bit fl, bit [2:0] esel, bit est);
    vec_t t;
    t.v = v; t.rs = rs; t.u = u; t.imm = imm; t.rd = rd;
    t.wr = wr; t.ld = ld; t.fl = fl; t.esel = esel; t.est = est;
    return t;
  endfunction

  task automatic clear_hist();
    rec_t e;
    e.v = 1'b0; e.rd = 4'h0; e.ld = 1'b0;
    hist.delete();
    repeat (3) hist.push_back(e);
  endtask

  function automatic bit m_stall();
    return id_valid && id_uses_rs && !id_use_imm && (id_rs != 4'h0) &&
           hist[0].v && hist[0].ld && (hist[0].rd == id_rs);
  endfunction

  function automatic bit [2:0] m_sel();
    if (id_use_imm) return 3'b100;
    if (!id_valid || !id_uses_rs || id_rs == 4'h0) return 3'b000;
    for (int i = 0; i < 3; i++)
      if (hist[i].v && hist[i].rd == id_rs) return 3'(i + 1);
    return 3'b000;
  endfunction

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic upd();
    bit   st;
    rec_t r;
    st = m_stall();
    if (flush) begin
      clear_hist();
    end else begin
      r.v  = st ? 1'b0 : (id_valid && id_wr);
      r.rd = id_rd;
      r.ld = id_is_load;
      hist.push_front(r);
      void'(hist.pop_back());
    end
    if (st && !flush && m_cnt < 65535) m_cnt++;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic set_inputs(input vec_t t);
    id_valid = t.v; id_rs = t.rs; id_uses_rs = t.u; id_use_imm = t.imm;
    id_rd = t.rd; id_wr = t.wr; id_is_load = t.ld; flush = t.fl;
  endtask

  task automatic chk_cnt(input string name);
`ifdef FWD_STALL_CNT_EN
    chk(name, stall_cnt, 16'(m_cnt));
`endif
  endtask

  // One cycle: compare at the falling edge, then step the model at the rising edge.
  task automatic run_cycle(input string tag, input bit use_tbl, input bit [2:0] tsel, input bit tst);
    bit [2:0] es;
    bit       est;
    @(negedge clk);
    es  = use_tbl ? tsel : m_sel();
    est = use_tbl ? tst : m_stall();
    chk({tag, " sel"}, {13'd0, fwd_sel}, {13'd0, es});
    chk({tag, " stall"}, {15'd0, stall}, {15'd0, est});
    chk_cnt({tag, " cnt"});
    @(posedge clk);
    upd();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_inputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    upd();
    #1;
  endtask

  initial begin
    // Reset behaviour with a live read of R3 and with an immediate operand.
    rst = 1'b1;
    set_inputs(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    clear_hist();
    m_cnt = 0;
    #1;
    chk("reset sel", {13'd0, fwd_sel}, 16'h0000);
    chk("reset stall", {15'd0, stall}, 16'h0000);
    chk_cnt("reset cnt");
    id_use_imm = 1'b1;
    #1;
    chk("reset imm sel", {13'd0, fwd_sel}, 16'h0004);
    id_use_imm = 1'b0;
    release_reset();

    // v rs u imm rd wr ld fl esel est
    tbl.push_back(mk(1, 5, 0, 0, 5, 1, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 3'b001, 0));
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 3'b010, 0));
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 3'b011, 0));
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 7, 1, 1, 0, 3'b000, 0));
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 3'b001, 1));
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 3'b010, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2, 1, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 9, 1, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2, 1, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0, 3'b001, 0));
    tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0, 3'b010, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 3'b100, 0));
    tbl.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 3'b000, 0));
    tbl.push_back(mk(0, 3, 1, 0, 0, 0, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 3'b011, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 6, 1, 1, 0, 3'b000, 0));
    tbl.push_back(mk(1, 6, 1, 1, 0, 0, 0, 0, 3'b100, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4, 1, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4, 1, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4, 1, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 1, 3'b001, 0));
    tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8, 1, 1, 0, 3'b000, 0));
    tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0, 1, 3'b001, 1));
    tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 10, 1, 0, 1, 3'b000, 0));
    tbl.push_back(mk(1, 10, 1, 0, 0, 0, 0, 0, 3'b000, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      set_inputs(tbl[i]);
      run_cycle($sformatf("vec%0d", i), 1'b1, tbl[i].esel, tbl[i].est);
    end

    // Reset asserted in the middle of a load-use stall drops stall at once.
    set_inputs(mk(1, 0, 0, 0, 7, 1, 1, 0, 0, 0));
    run_cycle("ms_load", 1'b1, 3'b000, 1'b0);
    set_inputs(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("ms stall before rst", {15'd0, stall}, 16'h0001);
    rst = 1'b1;
    #1;
    clear_hist();
    m_cnt = 0;
    chk("ms stall after rst", {15'd0, stall}, 16'h0000);
    chk("ms sel after rst", {13'd0, fwd_sel}, 16'h0000);
    chk_cnt("ms cnt after rst");
    release_reset();

    // Randomized traffic over a small register window to provoke frequent hits.
    for (int i = 0; i < 400; i++) begin
      id_valid   = ($urandom_range(0, 7) != 0);
      id_rs      = 4'($urandom_range(0, 3));
      id_uses_rs = ($urandom_range(0, 4) != 0);
      id_use_imm = ($urandom_range(0, 5) == 0);
      id_rd      = 4'($urandom_range(0, 3));
      id_wr      = ($urandom_range(0, 2) != 0);
      id_is_load = ($urandom_range(0, 2) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      run_cycle($sformatf("rnd%0d", i), 1'b0, 3'b000, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
